imem_responder: RTL
===================

# imem_responder

Instruction-memory responder serving the processor's instruction fetch interface (`instr_req`/`instr_adr` in, `instr_read`/`instr_valid` out). It latches a fetch request, waits a configurable number of wait states, then returns one 32-bit word from an internal word array with a single-cycle `instr_valid` strobe. A side load port fills the array before or during execution for test programs.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words in the array; power of two, 4 to 65536.
- `WAIT_CYCLES`, 2: extra cycles between request acceptance and response, 0 to 15.
- `CLK`  in  1: clock; all state updates on rising edge.
- `RES`  in  1: reset, synchronous, active-high.
- `instr_req`  in  1: fetch request, level-sensitive.
- `instr_adr`  in  32: byte address of the requested instruction.
- `instr_read`  out  32: fetched instruction word; holds its value until the next response.
- `instr_valid`  out  1: one-cycle strobe; `instr_read` is valid while high.
- `load_we`  in  1: array write enable.
- `load_adr`  in  log2(DEPTH_WORDS): word index for the write.
- `load_data`  in  32: write data.
- `adr_fault`  out  1: address error flag, valid with `instr_valid` (see Configuration).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if `instr_req`=1 at an edge, latch `instr_adr` and load the wait counter with `WAIT_CYCLES`. Next state is WAIT, or RESP directly if `WAIT_CYCLES`=0.
- WAIT: counter decrements once per cycle. At the edge where it reaches 0, go to RESP.
- Entering RESP: read the array at word index `latched_adr[log2(DEPTH_WORDS)+1:2]` into `instr_read`.
- RESP: `instr_valid`=1 for exactly one cycle, then IDLE unconditionally.
- `instr_req` is ignored in WAIT and RESP. Changes to `instr_adr` after acceptance have no effect.
- If `instr_req` is still high in IDLE after RESP, a new fetch starts at the current `instr_adr`. The requester drops `instr_req` in the `instr_valid` cycle if it does not want another fetch.
- Load port: `load_we`=1 writes `load_data` to `load_adr` at the edge, in any FSM state.
- Write and read of the same word on the same edge: the response returns the old data.
- A write landing before the RESP-entry edge is visible in the response.
- Reset (`RES`=1 at an edge, any state): state becomes IDLE, `instr_valid`=0, `instr_read`=0x00000000, `adr_fault`=0, counter=0. Array contents are preserved.
- Reset has priority over `instr_req` and over `load_we`. `load_we` is ignored while `RES`=1.

## Timing
- Request accepted at edge N. `instr_valid` goes high after edge N+1+WAIT_CYCLES and stays high for one cycle.
- Back-to-back fetches with `instr_req` held high: one response every WAIT_CYCLES+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Load port write latency: 1 edge.

## Configuration
- Macro: `IMEM_ADR_FAULT_EN`.
- Defined: the response sets `adr_fault`=1 and `instr_read`=0x00000013 (NOP) instead of array data when either of these holds for the latched address:
  - `latched_adr[1:0]` != 0 (misaligned);
  - `latched_adr >= 4*DEPTH_WORDS` (out of range).
- Defined: `adr_fault` updates only at RESP entry. Valid responses clear it to 0.
- Not defined: `adr_fault` is tied 0. Address bits [1:0] are ignored. Upper bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.

## Test plan
- Basic fetch, WAIT_CYCLES=2:
  - Stimulus: load word 3 = 0x00500093, reset, then `instr_req`=1 with `instr_adr`=0x0C at edge N.
  - Response: `instr_valid` high only in the cycle after edge N+3, `instr_read`=0x00500093.
- Held request:
  - Stimulus: `instr_req` held high, `instr_adr` stepping 0x0, 0x4, 0x8 on each `instr_valid`.
  - Response: strobes exactly 4 cycles apart; words 0, 1, 2 returned in order.
- Reset mid-WAIT:
  - Stimulus: assert `RES` one cycle after acceptance.
  - Response: next cycle `instr_valid`=0, `instr_read`=0; no strobe follows. A later fetch returns the pre-reset array contents.
- Load/read collision:
  - Stimulus: `load_we` to the latched word on the RESP-entry edge with 0xDEADBEEF, old value 0x11111111.
  - Response: returns 0x11111111. A second fetch of the same word returns 0xDEADBEEF.
- Address error, `IMEM_ADR_FAULT_EN` defined, DEPTH_WORDS=256:
  - Stimulus: fetch 0x402, then 0x400.
  - Response: both return `adr_fault`=1 with 0x00000013.
  - Without the macro: 0x400 returns word 0 with `adr_fault`=0.
- WAIT_CYCLES=0:
  - Stimulus: request accepted at edge N.
  - Response: `instr_valid` high in the cycle after edge N+1; with `instr_req` held, throughput is one response every 2 cycles.

Source files
------------

// File: rtl/imem_if.sv
// Instruction fetch bus plus side load port between a fetching master and imem_responder.
// Latency: n/a (bundle of wires only). Backpressure: none; fetch is request/strobe, load is fire-and-forget.
// Signals: instr_req/instr_adr (fetch request), instr_read/instr_valid/adr_fault (response),
//          load_we/load_adr/load_data (array fill). AW = word-index width of the array.
interface imem_if #(
    parameter int AW = 8
);
    logic          instr_req;
    logic [31:0]   instr_adr;
    logic [31:0]   instr_read;
    logic          instr_valid;
    logic          adr_fault;
    logic          load_we;
    logic [AW-1:0] load_adr;
    logic [31:0]   load_data;

    modport master (
        output instr_req, instr_adr, load_we, load_adr, load_data,
        input  instr_read, instr_valid, adr_fault
    );

    modport slave (
        input  instr_req, instr_adr, load_we, load_adr, load_data,
        output instr_read, instr_valid, adr_fault
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: latches a fetch, waits WAIT_CYCLES, returns one word with a 1-cycle instr_valid strobe.
// Latency: instr_valid high in the cycle after edge N+1+WAIT_CYCLES for a request accepted at edge N.
// Backpressure: none; instr_req is ignored while busy, so held requests yield one response every WAIT_CYCLES+2 cycles.
// Ports: CLK, RES (sync, active-high), bus (imem_if.slave: fetch request/response and array load port).
// Optional feature: define IMEM_ADR_FAULT_EN to flag misaligned / out-of-range fetches (adr_fault=1, NOP returned).
module imem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic CLK,
    input  logic RES,
    imem_if.slave bus
);
    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);
    localparam logic        NO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] latched_adr;
    logic [31:0] mem [DEPTH_WORDS];

    // With no wait states the array is read on the acceptance edge itself,
    // before latched_adr holds the request, so take the live address in IDLE.
    logic [31:0] fetch_adr;
    logic [31:0] rd_word;
    logic        resp_flt;
    logic [31:0] resp_dat;

    always_comb begin
        fetch_adr = (state == IDLE) ? bus.instr_adr : latched_adr;
        rd_word   = mem[fetch_adr[AW+1:2]];
    end

`ifdef IMEM_ADR_FAULT_EN
    always_comb begin
        resp_flt = (fetch_adr[1:0] != 2'b00) || (fetch_adr[31:AW+2] != '0);
        resp_dat = resp_flt ? NOP : rd_word;
    end
`else
    // Byte-offset and upper bits are don't-care: addresses wrap modulo the array size.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{fetch_adr[1:0], fetch_adr[31:AW+2]};
    always_comb begin
        resp_flt = 1'b0;
        resp_dat = rd_word;
    end
`endif

    // Array has no reset so contents survive RES; the read above samples
    // pre-edge contents, so a same-edge write returns old data.
    always_ff @(posedge CLK) begin
        if (!RES && bus.load_we) begin
            mem[bus.load_adr] <= bus.load_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state           <= IDLE;
            cnt             <= '0;
            latched_adr     <= '0;
            bus.instr_valid <= 1'b0;
            bus.instr_read  <= '0;
            bus.adr_fault   <= 1'b0;
        end else begin
            bus.instr_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.instr_req) begin
                        latched_adr <= bus.instr_adr;
                        if (NO_WAIT) begin
                            state          <= RESP;
                            bus.instr_read <= resp_dat;
                            bus.adr_fault  <= resp_flt;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_LD;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    // Counter reaches 0 on this edge: enter RESP and capture the response.
                    if (cnt == 4'd1) begin
                        state          <= RESP;
                        bus.instr_read <= resp_dat;
                        bus.adr_fault  <= resp_flt;
                    end
                end
                RESP: begin
                    bus.instr_valid <= 1'b1;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
